// File: rtl/dir_pkg.sv
// dir_pkg: shared bit indices, repeat-state type and counter-width helper for the direction-input path.
package dir_pkg;
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer followed by a per-bit debounce counter and stable level.
module debounce_bit import dir_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_stable
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_stable) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_stable = r_stable;
endmodule

// File: rtl/dir_input_conditioner.sv
// dir_input_conditioner: debounced, conflict-resolved direction buttons with one-cycle step pulses.
// Optional auto-repeat FSM enabled by defining DIR_AUTO_REPEAT_EN.
module dir_input_conditioner import dir_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_udlr,
  output logic [3:0] dir_udlr,
  output logic [3:0] held_udlr
);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("dir_input_conditioner: parameter out of range");
  end
  logic [3:0] w_stable, w_resolved, w_new;
  logic [3:0] r_held, r_held_d, r_dir;
  for (genvar b = 0; b < 4; b++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_btn    (btn_udlr[b]),
      .o_stable (w_stable[b])
    );
  end
  // Opposing directions cancel each other while both are held.
  always_comb begin
    w_resolved            = '0;
    w_resolved[DIR_UP]    = w_stable[DIR_UP]    & ~w_stable[DIR_DOWN];
    w_resolved[DIR_DOWN]  = w_stable[DIR_DOWN]  & ~w_stable[DIR_UP];
    w_resolved[DIR_LEFT]  = w_stable[DIR_LEFT]  & ~w_stable[DIR_RIGHT];
    w_resolved[DIR_RIGHT] = w_stable[DIR_RIGHT] & ~w_stable[DIR_LEFT];
    w_new                 = r_held & ~r_held_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held   <= '0;
      r_held_d <= '0;
    end else begin
      r_held   <= w_resolved;
      r_held_d <= r_held;
    end
  end
  // Pulses are masked with the next held value so a pulse never outlives its held bit.
`ifdef DIR_AUTO_REPEAT_EN
  localparam int RW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  rpt_state_t    r_state;
  logic [RW-1:0] r_rcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_dir   <= '0;
    end else if (r_held == '0) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_dir   <= '0;
    end else if (w_new != '0) begin
      r_state <= HOLD;
      r_rcnt  <= '0;
      r_dir   <= w_new & w_resolved;
    end else if (r_state == HOLD && r_rcnt == RW'(REPEAT_DELAY - 1)) begin
      r_state <= REPEAT;
      r_rcnt  <= '0;
      r_dir   <= r_held & w_resolved;
    end else if (r_state == REPEAT && r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
      r_rcnt <= '0;
      r_dir  <= r_held & w_resolved;
    end else begin
      r_rcnt <= (r_state == IDLE) ? '0 : r_rcnt + 1'b1;
      r_dir  <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dir <= '0;
    else r_dir <= w_new & w_resolved;
  end
`endif
  assign dir_udlr  = r_dir;
  assign held_udlr = r_held;
endmodule
